pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised program-counter controller; sits between instruction memory and decode/execute.
//  - Owns the PC register and drives the fetch request handshake.
//  - Resolves branches and jumps itself, from raw rs1/rs2 operands (signed and unsigned compares).
//  - Traps on misaligned control-flow targets.
//  - Accepts an external redirect (interrupt/flush) with defined priority.
// PARAMETERS
//  XLEN      32            data/address width
//  INITPC    32'h0000_0000 PC value after reset
//  TRAP_VEC  32'h0000_0010 PC loaded on misaligned-target trap
// PORTS
//  clk           in   1     system clock
//  nRST          in   1     asynchronous active-low reset
//  imem_req      out  1     fetch request; held high until imem_ack
//  imem_addr     out  XLEN  fetch address (= PC)
//  imem_ack      in   1     fetch complete; instruction available to decode
//  exec_valid    in   1     cuOP/operands for the current PC are valid
//  stall         in   1     hold in EXEC; no commit this cycle
//  cuOP          in   6     cuOPType from cpu_pkg
//  rs1Read       in   XLEN  register rs1 value
//  rs2Read       in   XLEN  register rs2 value
//  immExt        in   XLEN  sign-extended immediate
//  redirect_vld  in   1     external redirect request
//  redirect_pc   in   XLEN  external redirect target
//  link_addr     out  XLEN  PC+4, for JAL/JALR writeback
//  retire        out  1     1-cycle pulse per committed instruction
//  trap          out  1     1-cycle pulse, misaligned target
//  trap_epc      out  XLEN  PC of faulting instruction (valid with trap)
//  trap_badaddr  out  XLEN  offending target (valid with trap)
// BEHAVIOUR
//  - Reset: state=FETCH, PC=INITPC, imem_req=1, retire=trap=0, trap_epc=trap_badaddr=0.
//  - FETCH: imem_req=1, imem_addr=PC; on imem_ack -> EXEC. Fetch takes at least 1 cycle.
//  - EXEC: imem_req=0; waits for exec_valid && !stall, then commits (1 cycle); stall takes precedence.
//  - Branch condition, computed internally:
//    - BEQ/BNE: rs1==rs2 / rs1!=rs2.
//    - BLT/BGE: signed compare.
//    - BLTU/BGEU: unsigned compare.
//  - Targets, all sums mod 2^XLEN (wrap, no overflow flag):
//    - JAL and taken branch: PC+immExt.
//    - JALR: (rs1Read+immExt) & ~1.
//    - default and not-taken: PC+4.
//  - Commit:
//    - target[1:0]==0: PC<=target, retire=1 -> FETCH.
//    - target[1:0]!=0: -> TRAP; PC unchanged, no retire.
//  - TRAP (1 cycle): trap=1, trap_epc=PC, trap_badaddr=target; PC<=TRAP_VEC -> FETCH.
//  - link_addr = PC+4, combinational, valid in every state.
//  - redirect_vld wins over everything else in any state:
//    - PC<=redirect_pc -> FETCH, no retire/trap.
//    - in FETCH, an outstanding imem_ack on the same cycle is discarded.
//  - redirect_pc is not alignment-checked.
//  - Async reset mid-fetch/mid-trap: immediately back to reset values, with no pulse emitted.
//  - trap_epc/trap_badaddr hold their last value until the next trap.
// CONFIGURATION
//  PC_PERF_EN defined:
//  - adds ports perf_retired[31:0] and perf_taken[31:0].
//  - counters reset to 0 and wrap at 2^32.
//  - perf_retired increments on retire.
//  - perf_taken increments on a committed taken branch or jump.
//  PC_PERF_EN undefined: no ports, no counter logic; all other behaviour identical.
// STRUCTURE
//  cpu_pkg:
//  - cuOPType enum (existing).
//  - new pcStateType enum {FETCH, EXEC, TRAP}.
//  - constants PC_INCR=4, ALIGN_MASK=2'b11.
//  Sub-module branch_cmp (comb):
//  - inputs: cuOP, rs1, rs2.
//  - outputs: is_jump, taken.
//  Top: state register, PC register, target mux, trap capture, optional counters.
// TESTING
//  1. Reset release, imem_ack after 3 cycles -> imem_addr=0x0 held 3 cycles; EXEC; ADD commit -> PC=0x4, retire=1.
//  2. PC=0x100, BLT rs1=0xFFFF_FFFF, rs2=1, imm=0x20 -> PC=0x120. Same operands with BLTU -> PC=0x104.
//  3. PC=0x40, JALR rs1=0x203, imm=0 -> target 0x202 misaligned.
//     Expected: trap=1, trap_epc=0x40, trap_badaddr=0x202; next cycle PC=0x10.
//  4. PC=0xFFFF_FFFC, default op -> PC wraps to 0x0. JAL imm=0xFFFF_FFF8 at PC=0x8 -> PC=0x0.
//  5. EXEC, stall=1 with exec_valid=1 for 4 cycles -> no retire, PC stable; stall=0 -> commit.
//  6. FETCH, redirect_vld=1 with redirect_pc=0x800 on the same cycle as imem_ack -> PC=0x800, FETCH, retire=0.
//     With PC_PERF_EN: case 2 (BLT) -> perf_taken=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - control-unit opcode and PC state types shared by the fetch controller
package cpu_pkg;

    typedef enum logic [5:0] {
        CU_NOP  = 6'h00,
        CU_ADD  = 6'h01,
        CU_SUB  = 6'h02,
        CU_AND  = 6'h03,
        CU_OR   = 6'h04,
        CU_XOR  = 6'h05,
        CU_LW   = 6'h08,
        CU_SW   = 6'h09,
        CU_BEQ  = 6'h10,
        CU_BNE  = 6'h11,
        CU_BLT  = 6'h12,
        CU_BGE  = 6'h13,
        CU_BLTU = 6'h14,
        CU_BGEU = 6'h15,
        CU_JAL  = 6'h18,
        CU_JALR = 6'h19
    } cuOPType;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        TRAP  = 2'd2
    } pcStateType;

    localparam int         PC_INCR    = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition and jump decode from raw operands
module branch_cmp
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  cuOPType           cuOP,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic              is_jump,
    output logic              taken
);

    // taken covers conditional branches only; jumps are reported through is_jump
    always_comb begin
        is_jump = 1'b0;
        taken   = 1'b0;
        case (cuOP)
            CU_BEQ:  taken = (rs1 == rs2);
            CU_BNE:  taken = (rs1 != rs2);
            CU_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            CU_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            CU_BLTU: taken = (rs1 <  rs2);
            CU_BGEU: taken = (rs1 >= rs2);
            CU_JAL,
            CU_JALR: is_jump = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, fetch handshake, branch resolve and misalign trap; PC_PERF_EN adds counters
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] INITPC   = '0,
    parameter logic [XLEN-1:0] TRAP_VEC = 'h10
) (
    input  logic              clk,
    input  logic              nRST,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic              exec_valid,
    input  logic              stall,
    input  cuOPType           cuOP,
    input  logic [XLEN-1:0]   rs1Read,
    input  logic [XLEN-1:0]   rs2Read,
    input  logic [XLEN-1:0]   immExt,
    input  logic              redirect_vld,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic [XLEN-1:0]   link_addr,
    output logic              retire,
    output logic              trap,
    output logic [XLEN-1:0]   trap_epc,
    output logic [XLEN-1:0]   trap_badaddr
`ifdef PC_PERF_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_taken
`endif
);

    pcStateType      state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic            is_jump;
    logic            taken;
    logic            misaligned;
    logic            commit;
    logic            capture;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .cuOP    (cuOP),
        .rs1     (rs1Read),
        .rs2     (rs2Read),
        .is_jump (is_jump),
        .taken   (taken)
    );

    assign pc_plus4  = pc + XLEN'(PC_INCR);
    assign jalr_sum  = rs1Read + immExt;
    assign link_addr = pc_plus4;
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);
    assign commit    = (state == EXEC) && exec_valid && !stall;

    always_comb begin
        target = pc_plus4;
        if (is_jump && (cuOP == CU_JALR))
            target = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_jump || taken)
            target = pc + immExt;
    end

    assign misaligned = |(target[1:0] & ALIGN_MASK);

    // redirect preempts every state, so it is resolved before the state decode
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        retire    = 1'b0;
        trap      = 1'b0;
        capture   = 1'b0;
        if (redirect_vld) begin
            state_nxt = FETCH;
            pc_nxt    = redirect_pc;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack)
                        state_nxt = EXEC;
                end
                EXEC: begin
                    if (commit) begin
                        if (misaligned) begin
                            state_nxt = TRAP;
                            capture   = 1'b1;
                        end else begin
                            state_nxt = FETCH;
                            pc_nxt    = target;
                            retire    = 1'b1;
                        end
                    end
                end
                TRAP: begin
                    trap      = 1'b1;
                    state_nxt = FETCH;
                    pc_nxt    = TRAP_VEC;
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state        <= FETCH;
            pc           <= INITPC;
            trap_epc     <= '0;
            trap_badaddr <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                trap_epc     <= pc;
                trap_badaddr <= target;
            end
        end
    end

`ifdef PC_PERF_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            perf_retired <= '0;
            perf_taken   <= '0;
        end else if (retire) begin
            perf_retired <= perf_retired + 32'd1;
            if (is_jump || taken)
                perf_taken <= perf_taken + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl; PC_PERF_EN also checks counters
module tb_pc_fetch_ctrl;
    import cpu_pkg::*;

    localparam logic [31:0] INITPC   = 32'h0;
    localparam logic [31:0] TRAP_VEC = 32'h10;

    logic        clk, nRST;
    logic        imem_req, imem_ack, exec_valid, stall;
    logic [31:0] imem_addr, rs1Read, rs2Read, immExt, redirect_pc;
    logic        redirect_vld, retire, trap;
    logic [31:0] link_addr, trap_epc, trap_badaddr;
    cuOPType     cuOP;
`ifdef PC_PERF_EN
    logic [31:0] perf_retired, perf_taken;
`endif

    pc_fetch_ctrl #(.XLEN(32), .INITPC(INITPC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .exec_valid   (exec_valid),
        .stall        (stall),
        .cuOP         (cuOP),
        .rs1Read      (rs1Read),
        .rs2Read      (rs2Read),
        .immExt       (immExt),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .link_addr    (link_addr),
        .retire       (retire),
        .trap         (trap),
        .trap_epc     (trap_epc),
`ifdef PC_PERF_EN
        .perf_retired (perf_retired),
        .perf_taken   (perf_taken),
`endif
        .trap_badaddr (trap_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_trap;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic [31:0] next_pc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mpc;
    int unsigned m_ret, m_tkn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural next-PC rule: branches/jumps redirect by offset, JALR by register, else fall through
    function automatic logic [31:0] ref_target(input cuOPType op, input logic [31:0] pc,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] imm, output bit tk);
        tk = 1'b0;
        case (op)
            CU_BEQ:  tk = (a == b);
            CU_BNE:  tk = (a != b);
            CU_BLT:  tk = ($signed(a) <  $signed(b));
            CU_BGE:  tk = ($signed(a) >= $signed(b));
            CU_BLTU: tk = (a <  b);
            CU_BGEU: tk = (a >= b);
            CU_JAL:  tk = 1'b1;
            CU_JALR: begin
                tk = 1'b1;
                return (a + imm) & 32'hFFFF_FFFE;
            end
            default: tk = 1'b0;
        endcase
        return tk ? pc + imm : pc + 32'd4;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input cuOPType op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input int d, input int s, input bit rst_in_trap);
        logic [31:0] tgt;
        bit          tk;
        exp_t        e;
        imem_ack = 1'b0; exec_valid = 1'b0; stall = 1'b0;
        for (int i = 0; i < d; i++) begin
            chk("fetch_req", 32'(imem_req), 32'd1);
            chk("fetch_addr", imem_addr, mpc);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("exec_req", 32'(imem_req), 32'd0);
        cuOP = op; rs1Read = a; rs2Read = b; immExt = imm;
        exec_valid = 1'b1;
        stall = (s > 0);
        for (int i = 0; i < s; i++) begin
            chk("stall_pc", imem_addr, mpc);
            tick();
        end
        stall = 1'b0;
        tgt = ref_target(op, mpc, a, b, imm, tk);
        if (tgt[1:0] == 2'b00) begin
            e.is_trap = 1'b0; e.pc = mpc; e.badaddr = '0; e.next_pc = tgt;
            sb.push_back(e);
            m_ret++;
            if (tk) m_tkn++;
            tick();
            exec_valid = 1'b0;
            mpc = tgt;
`ifdef PC_PERF_EN
            chk("perf_retired", perf_retired, m_ret);
            chk("perf_taken", perf_taken, m_tkn);
`endif
        end else begin
            e.is_trap = 1'b1; e.pc = mpc; e.badaddr = tgt; e.next_pc = TRAP_VEC;
            if (!rst_in_trap) sb.push_back(e);
            tick();
            exec_valid = 1'b0;
            if (rst_in_trap) begin
                nRST = 1'b0;
                #1;
                chk("rst_trap_pulse", 32'(trap), 32'd0);
                chk("rst_trap_req", 32'(imem_req), 32'd1);
                chk("rst_trap_addr", imem_addr, INITPC);
                chk("rst_trap_epc", trap_epc, 32'd0);
                chk("rst_trap_badaddr", trap_badaddr, 32'd0);
                tick();
                nRST = 1'b1;
                mpc = INITPC; m_ret = 0; m_tkn = 0;
            end else begin
                tick();
                mpc = TRAP_VEC;
            end
        end
    endtask

    task automatic redir(input logic [31:0] p, input bit with_ack);
        redirect_vld = 1'b1; redirect_pc = p; imem_ack = with_ack;
        tick();
        redirect_vld = 1'b0; imem_ack = 1'b0;
        mpc = p;
        chk("redir_req", 32'(imem_req), 32'd1);
        chk("redir_pc", imem_addr, p);
    endtask

    task automatic redir_exec(input logic [31:0] p);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        cuOP = CU_ADD; exec_valid = 1'b1; stall = 1'b0;
        redirect_vld = 1'b1; redirect_pc = p;
        tick();
        redirect_vld = 1'b0; exec_valid = 1'b0;
        mpc = p;
        chk("redir_exec_req", 32'(imem_req), 32'd1);
        chk("redir_exec_pc", imem_addr, p);
    endtask

    // Monitor: every retire/trap pulse must match the oldest expected commit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1 || trap === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, retire, trap}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("trap_flag", 32'(trap), 32'(e.is_trap));
                    chk("retire_flag", 32'(retire), 32'(!e.is_trap));
                    chk("commit_pc", imem_addr, e.pc);
                    chk("link_addr", link_addr, e.pc + 32'd4);
                    if (e.is_trap) begin
                        chk("trap_epc", trap_epc, e.pc);
                        chk("trap_badaddr", trap_badaddr, e.badaddr);
                    end
                    @(negedge clk);
                    chk("next_pc", imem_addr, e.next_pc);
                end
            end
        end
    end

    cuOPType ops[11] = '{CU_ADD, CU_SUB, CU_NOP, CU_BEQ, CU_BNE, CU_BLT,
                         CU_BGE, CU_BLTU, CU_BGEU, CU_JAL, CU_JALR};

    initial begin
        logic [31:0] a, b, imm, p;
        nRST = 1'b0; imem_ack = 1'b0; exec_valid = 1'b0; stall = 1'b0;
        cuOP = CU_NOP; rs1Read = '0; rs2Read = '0; immExt = '0;
        redirect_vld = 1'b0; redirect_pc = '0;
        mpc = INITPC; m_ret = 0; m_tkn = 0;
        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, INITPC);
        chk("rst_retire", 32'(retire), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_epc", trap_epc, 32'd0);
        chk("rst_badaddr", trap_badaddr, 32'd0);
        chk("rst_link", link_addr, 32'd4);
        nRST = 1'b1;

        run(CU_ADD, 32'd5, 32'd7, 32'd0, 3, 0, 1'b0);
        redir(32'h100, 1'b0);
        run(CU_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 1, 0, 1'b0);
        redir(32'h100, 1'b1);
        run(CU_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 0, 0, 1'b0);
        redir(32'h40, 1'b0);
        run(CU_JALR, 32'h203, 32'd0, 32'd0, 0, 0, 1'b0);
        redir(32'hFFFF_FFFC, 1'b0);
        run(CU_ADD, 32'd0, 32'd0, 32'd0, 1, 0, 1'b0);
        redir(32'h8, 1'b0);
        run(CU_JAL, 32'd0, 32'd0, 32'hFFFF_FFF8, 0, 0, 1'b0);
        run(CU_SUB, 32'd1, 32'd2, 32'd0, 1, 4, 1'b0);
        redir(32'h800, 1'b1);
        redir_exec(32'h300);

        run(CU_ADD, 32'd0, 32'd0, 32'd0, 1, 0, 1'b0);
        redir(32'h44, 1'b0);
        tick();
        nRST = 1'b0;
        #1;
        chk("rst_fetch_addr", imem_addr, INITPC);
        chk("rst_fetch_req", 32'(imem_req), 32'd1);
        tick();
        nRST = 1'b1;
        mpc = INITPC; m_ret = 0; m_tkn = 0;
        redir(32'h40, 1'b0);
        run(CU_JALR, 32'h203, 32'd0, 32'd0, 0, 0, 1'b1);

        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0)
                imm = $urandom;
            else
                imm = (($urandom_range(0, 1) == 1) ? 32'hFFFF_F000 : 32'h0) | ($urandom & 32'h0000_0FFC);
            if ($urandom_range(0, 5) == 0) begin
                p = $urandom & 32'hFFFF_FFFC;
                redir(p, 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 7) == 0) begin
                p = $urandom & 32'hFFFF_FFFC;
                redir_exec(p);
            end
            run(ops[$urandom_range(0, 10)], a, b, imm, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
